// File: rtl/hazard_forward_unit.sv
// Hazard and bypass unit: DEPTH-entry in-flight destination table feeding operand
// bypass, load-use stall detection and the register-file write-back port.
module hazard_forward_unit #(
  parameter int XLEN    = 32,
  parameter int RA_W    = 5,
  parameter int DEPTH   = 3,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_valid_i,
  input  logic [RA_W-1:0]         issue_rd_i,
  input  logic                    issue_wen_i,
  input  logic                    issue_is_load_i,
  input  logic [NUM_SRC*RA_W-1:0] src_sel_i,
  input  logic [NUM_SRC*XLEN-1:0] src_rf_value_i,
  input  logic [XLEN-1:0]         ex_result_i,
  input  logic [XLEN-1:0]         mem_result_i,
  input  logic                    flush_i,
  output logic                    stall_o,
  output logic [NUM_SRC*XLEN-1:0] src_value_o,
  output logic [NUM_SRC-1:0]      fwd_hit_o,
  output logic                    wb_valid_o,
  output logic [RA_W-1:0]         wb_rd_o,
  output logic [XLEN-1:0]         wb_value_o,
  output logic [CNT_W-1:0]        stall_count_o
);

  // Issue handshake: decode holds its instruction while stall_o is high; the
  // instruction enters entry 0 only on an edge where issue_valid_i & ~stall_o & ~flush_i.

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] wen_q, wen_d;
  logic [DEPTH-1:0] load_q, load_d;
  logic [DEPTH-1:0] rdy_q, rdy_d;
  logic [RA_W-1:0]  rd_q  [DEPTH];
  logic [RA_W-1:0]  rd_d  [DEPTH];
  logic [XLEN-1:0]  val_q [DEPTH];
  logic [XLEN-1:0]  val_d [DEPTH];
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic [DEPTH-1:0]   match [NUM_SRC];
  logic [NUM_SRC-1:0] ld_use;
  logic               accept;

  always_comb begin
    src_value_o = src_rf_value_i;
    fwd_hit_o   = '0;
    ld_use      = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      match[s] = '0;
      for (int k = 0; k < DEPTH; k++) begin
        match[s][k] = valid_q[k] & wen_q[k] &
                      (rd_q[k] == src_sel_i[s*RA_W +: RA_W]) &
                      (src_sel_i[s*RA_W +: RA_W] != '0);
      end
      ld_use[s] = match[s][0] & load_q[0];
      // Walk oldest to youngest so the youngest match overrides.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (match[s][k]) begin
          fwd_hit_o[s] = 1'b1;
          if (k == 0 && !load_q[0]) begin
            src_value_o[s*XLEN +: XLEN] = ex_result_i;
          end else if (k == 1 && !rdy_q[1]) begin
            src_value_o[s*XLEN +: XLEN] = mem_result_i;
          end else begin
            src_value_o[s*XLEN +: XLEN] = val_q[k];
          end
        end
      end
    end
  end

  assign stall_o = issue_valid_i & (|ld_use);
  assign accept  = issue_valid_i & ~stall_o & ~flush_i;

  always_comb begin
    valid_d[0] = accept;
    rd_d[0]    = issue_rd_i;
    wen_d[0]   = issue_wen_i;
    load_d[0]  = issue_is_load_i;
    rdy_d[0]   = 1'b0;
    val_d[0]   = '0;

    // Flush kills the instruction currently in execute as it moves on.
    valid_d[1] = valid_q[0] & ~flush_i;
    rd_d[1]    = rd_q[0];
    wen_d[1]   = wen_q[0];
    load_d[1]  = load_q[0];
    rdy_d[1]   = valid_q[0] & ~load_q[0];
    val_d[1]   = (valid_q[0] && !load_q[0]) ? ex_result_i : '0;

    for (int k = 2; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k-1];
      rd_d[k]    = rd_q[k-1];
      wen_d[k]   = wen_q[k-1];
      load_d[k]  = load_q[k-1];
      rdy_d[k]   = rdy_q[k-1];
      val_d[k]   = val_q[k-1];
      if (k == 2 && valid_q[1] && load_q[1] && !rdy_q[1]) begin
        rdy_d[k] = 1'b1;
        val_d[k] = mem_result_i;
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_o && !flush_i && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      wen_q         <= '0;
      load_q        <= '0;
      rdy_q         <= '0;
      stall_count_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k]  <= '0;
        val_q[k] <= '0;
      end
    end else begin
      valid_q       <= valid_d;
      wen_q         <= wen_d;
      load_q        <= load_d;
      rdy_q         <= rdy_d;
      stall_count_q <= stall_count_d;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k]  <= rd_d[k];
        val_q[k] <= val_d[k];
      end
    end
  end

  // With DEPTH=2 a load retires straight from the memory stage, so take mem_result.
  assign wb_valid_o    = valid_q[DEPTH-1] & wen_q[DEPTH-1] & (rd_q[DEPTH-1] != '0);
  assign wb_rd_o       = rd_q[DEPTH-1];
  assign wb_value_o    = (load_q[DEPTH-1] && !rdy_q[DEPTH-1]) ? mem_result_i : val_q[DEPTH-1];
  assign stall_count_o = stall_count_q;

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised hazard and bypass unit for the pipelined RISC-V core. It replaces the single-entry, rs1-only RAW hazard path with a DEPTH-entry in-flight destination table. It forwards results to NUM_SRC decode operands, stalls issue on load-use, and drives the register-file write-back port from the oldest table entry. It sits between decode, the execute/memory stages and register_file.

## Interface
- XLEN, 32, datapath width
- RA_W, 5, register address width
- DEPTH, 3, in-flight entries after decode (entry 0 = execute, entry DEPTH-1 = write-back); legal range 2..8
- NUM_SRC, 2, forwarded source operands per issuing instruction
- CNT_W, 16, stall counter width

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- issue_valid  in  1  decode presents an instruction this cycle
- issue_rd  in  RA_W  destination register of the issuing instruction
- issue_wen  in  1  issuing instruction writes rd
- issue_is_load  in  1  issuing instruction is a load
- src_sel  in  NUM_SRC*RA_W  packed source register indices, source i at [i*RA_W +: RA_W]
- src_rf_value  in  NUM_SRC*XLEN  register_file read data per source
- ex_result  in  XLEN  combinational ALU result for entry 0
- mem_result  in  XLEN  combinational load data for entry 1
- flush  in  1  kill the issuing instruction and entry 0
- stall  out  1  hold decode; combinational
- src_value  out  NUM_SRC*XLEN  operand after bypass
- fwd_hit  out  NUM_SRC  bit i set when source i was bypassed
- wb_valid  out  1  register-file write enable
- wb_rd  out  RA_W  write-back register
- wb_value  out  XLEN  write-back data
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- Each table entry holds: valid, rd, wen, is_load, ready, value.
- The table shifts every clock: entry k moves to k+1, and entry DEPTH-1 retires.
  - Entry 0 loads {issue_valid & ~stall & ~flush, issue_rd, issue_wen, issue_is_load}, with ready=0.
  - Entry 0 to 1 capture: a non-load takes value=ex_result, ready=1. A load keeps ready=0.
  - Entry 1 to 2 capture: a not-ready load takes value=mem_result, ready=1.
- Matching: a source matches entry k when valid & wen & rd==src_sel & src_sel!=0.
- Bypass per source: the youngest matching entry (lowest k) wins.
  - k=0 non-load: ex_result.
  - k=1 with ready=0: mem_result.
  - Otherwise: the stored value.
  - No match: src_rf_value, with fwd_hit=0. x0 never forwards.
- Load-use: stall=1 when issue_valid and any source matches entry 0 with is_load=1.
  - On that edge entry 0 becomes a bubble (valid=0). Older entries still advance.
- Flush:
  - Entry 0 is invalidated at the edge.
  - The issuing instruction is dropped.
  - Entries 1..DEPTH-1 continue unchanged.
  - Flush has priority over stall. stall still reports combinationally, but stall_count does not increment while flush=1.
- Write-back: wb_valid = entry[DEPTH-1].valid & wen & rd!=0. wb_rd and wb_value are the entry's fields.
  - Because entry DEPTH-1 is also in the match search, a same-cycle register-file write is covered.
- stall_count increments on each edge with stall=1 & ~flush and saturates at all-ones.

## Timing
- Reset (asynchronous): all entries valid=0, ready=0, rd=0, value=0; stall_count=0.
  - Outputs under reset: stall=0, fwd_hit=0, wb_valid=0, wb_rd=0, wb_value=0, src_value=src_rf_value.
- Reset mid-operation discards all in-flight entries immediately. No write-back occurs after rst_n falls.
- Result latency: a non-load is forwardable from ex_result in the cycle after issue, and from stored value thereafter.
- Write-back appears DEPTH cycles after issue.
- A load costs exactly one stall cycle for a dependent instruction issued immediately behind it. A gap of one or more cycles costs zero stall cycles.
- A duplicate rd in several entries always resolves to the youngest entry.
- stall, src_value and fwd_hit are purely combinational. Table state and stall_count are registered.

## Test plan
- Reset check: assert rst_n=0 mid-stream with 3 valid entries, then release. Required: wb_valid=0, stall=0, stall_count=0; src_value equals src_rf_value.
- Back-to-back ALU chain: issue `addi x5` with ex_result=0x10, then issue an instruction reading rs1=x5. Required: fwd_hit[0]=1, src_value[0]=0x10, stall=0. In cycle 3 (DEPTH=3): wb_valid=1, wb_rd=5, wb_value=0x10.
- Load-use: issue a load to x7, then issue a reader of x7 (mem_result=0xDEADBEEF on the next cycle).
  - Required: stall=1 for exactly 1 cycle, stall_count=1.
  - The re-presented reader gets src_value=0xDEADBEEF with fwd_hit=1.
- Youngest-wins: x3 is written with 0x1 then with 0x2 in consecutive issues; the third issue reads x3. Required: src_value=0x2.
- x0 and flush:
  - A write to x0 with value 0x55, then a reader of x0. Required: fwd_hit=0, wb_valid=0.
  - A flush on the same cycle as a load-use stall. Required: entry 0 invalid next cycle, stall_count unchanged.
- Saturation: with CNT_W=4, force 20 stall cycles. Required: stall_count=0xF.
